// File: rtl/dice_pkg.sv
// Shared definitions for the two-player dice round sequencer.
// Contents: FSM state encoding, die value limits, winner codes, and small
// helpers for die legality and round judging.
package dice_pkg;

    typedef enum logic [1:0] {
        WAIT_P1   = 2'd0,
        WAIT_P2   = 2'd1,
        RESULT    = 2'd2,
        GAME_OVER = 2'd3
    } state_e;

    localparam logic [2:0] DIE_MIN = 3'd1;
    localparam logic [2:0] DIE_MAX = 3'd6;
    localparam logic [2:0] DREI    = 3'd3;

    localparam logic [1:0] W_NONE = 2'b00;
    localparam logic [1:0] W_P1   = 2'b01;
    localparam logic [1:0] W_P2   = 2'b10;
    localparam logic [1:0] W_TIE  = 2'b11;

    function automatic logic die_legal(input logic [2:0] v);
        return (v >= DIE_MIN) && (v <= DIE_MAX);
    endfunction

    function automatic logic [1:0] judge(input logic [2:0] d1, input logic [2:0] d2);
        if (d1 > d2) begin
            return W_P1;
        end else if (d2 > d1) begin
            return W_P2;
        end
        return W_TIE;
    endfunction

endpackage

// File: rtl/dice_round_sequencer_hold_timer.sv
// hold_timer: counts HOLD_CYCLES clock cycles after a start pulse and emits a
// one-cycle done pulse on the last counted cycle.
// Ports:
//   clk_i   - system clock
//   rst_i   - synchronous reset, active-high
//   start_i - one-cycle pulse; (re)starts the count at 0
//   done_o  - high during the cycle in which the count equals HOLD_CYCLES-1
module hold_timer #(
    parameter int HOLD_CYCLES = 10_000_000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic done_o
);

    // A single-cycle hold still needs a 1-bit counter to carry the running flag.
    localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] count_q, count_d;
    logic          running_q, running_d;

    always_comb begin
        count_d   = count_q;
        running_d = running_q;
        if (start_i) begin
            count_d   = '0;
            running_d = 1'b1;
        end else if (running_q) begin
            if (count_q == LAST) begin
                running_d = 1'b0;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            running_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            running_q <= running_d;
        end
    end

    assign done_o = running_q && (count_q == LAST);

endmodule

// File: rtl/dice_round_sequencer.sv
// dice_round_sequencer: turn-based round controller for the two-player dice game.
// Latches each player's die in turn order, judges the round, keeps saturating
// scores, holds the result for HOLD_CYCLES and detects end of game.
// Ports:
//   clk_i, rst_i            - clock, synchronous active-high reset
//   roll_req1_i/roll_req2_i - one-cycle debounced roll pulses for P1/P2
//   running_val_i           - free-running die value (legal 1..6)
//   stored1_o/stored2_o     - latched dice, 0 = none
//   rolled1_o/rolled2_o     - latched die valid flags
//   turn_o                  - 0 = P1 may roll, 1 = P2 may roll
//   result_valid_o          - winner/dreimann valid
//   winner_o                - 01 P1, 10 P2, 11 tie, 00 none
//   dreimann_o              - bit0/bit1: P1/P2 die == 3
//   score1_o/score2_o       - saturating scores
//   game_over_o             - a score reached WIN_SCORE
//   state_o                 - current FSM state (debug visibility)
//
// Roll request semantics: a roll pulse has no ready/acknowledge. It is accepted
// only in the owning player's WAIT state; if the die value is illegal at that
// moment the request stays pending and the first legal value on a later cycle
// is latched. All other pulses are dropped without effect.
module dice_round_sequencer
    import dice_pkg::*;
#(
    parameter int HOLD_CYCLES = 10_000_000,
    parameter int WIN_SCORE   = 5,
    parameter int SCORE_W     = 3
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               roll_req1_i,
    input  logic               roll_req2_i,
    input  logic [2:0]         running_val_i,
    output logic [2:0]         stored1_o,
    output logic [2:0]         stored2_o,
    output logic               rolled1_o,
    output logic               rolled2_o,
    output logic               turn_o,
    output logic               result_valid_o,
    output logic [1:0]         winner_o,
    output logic [1:0]         dreimann_o,
    output logic [SCORE_W-1:0] score1_o,
    output logic [SCORE_W-1:0] score2_o,
    output logic               game_over_o,
    output state_e             state_o
);

    localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);

    state_e             state_q, state_d;
    logic [2:0]         stored1_q, stored1_d, stored2_q, stored2_d;
    logic               rolled1_q, rolled1_d, rolled2_q, rolled2_d;
    logic               pending_q, pending_d;
    logic               judge_q, judge_d;
    logic [1:0]         winner_q, winner_d, dreimann_q, dreimann_d;
    logic               result_valid_q, result_valid_d;
    logic [SCORE_W-1:0] score1_q, score1_d, score2_q, score2_d;

    logic hold_done;
    logic val_legal, p1_try, p2_try, p1_take, p2_take, win_reached, round_clear, restart;

    assign val_legal   = die_legal(running_val_i);
    // A pending request keeps trying every cycle until a legal value shows up.
    assign p1_try      = (state_q == WAIT_P1) && (roll_req1_i || pending_q);
    assign p2_try      = (state_q == WAIT_P2) && (roll_req2_i || pending_q);
    assign p1_take     = p1_try && val_legal;
    assign p2_take     = p2_try && val_legal;
    assign win_reached = (score1_q == WIN) || (score2_q == WIN);
    assign round_clear = (state_q == RESULT) && hold_done && !win_reached;
    assign restart     = (state_q == GAME_OVER) && roll_req1_i;

    // judge_q marks the RESULT entry cycle; it also starts the hold timer so
    // the hold begins on the same edge the verdict becomes visible.
    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .start_i(judge_q),
        .done_o (hold_done)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= WAIT_P1;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            WAIT_P1:   if (p1_take) state_d = WAIT_P2;
            WAIT_P2:   if (p2_take) state_d = RESULT;
            RESULT:    if (hold_done) state_d = win_reached ? GAME_OVER : WAIT_P1;
            GAME_OVER: if (roll_req1_i) state_d = WAIT_P1;
            default:   state_d = WAIT_P1;
        endcase
    end

    // FSM-decoded outputs
    always_comb begin
        turn_o      = (state_q == WAIT_P2);
        game_over_o = (state_q == GAME_OVER);
        state_o     = state_q;
    end

    // Datapath next-state: die latches, judge, scores
    always_comb begin
        stored1_d      = stored1_q;
        stored2_d      = stored2_q;
        rolled1_d      = rolled1_q;
        rolled2_d      = rolled2_q;
        pending_d      = pending_q;
        judge_d        = p2_take;
        winner_d       = winner_q;
        dreimann_d     = dreimann_q;
        result_valid_d = result_valid_q;
        score1_d       = score1_q;
        score2_d       = score2_q;

        if (p1_try || p2_try) begin
            pending_d = !val_legal;
        end
        if (p1_take) begin
            stored1_d = running_val_i;
            rolled1_d = 1'b1;
        end
        if (p2_take) begin
            stored2_d = running_val_i;
            rolled2_d = 1'b1;
        end

        if (judge_q) begin
            winner_d       = judge(stored1_q, stored2_q);
            dreimann_d     = {stored2_q == DREI, stored1_q == DREI};
            result_valid_d = 1'b1;
            // Scores never exceed WIN because the game stops once one gets there.
            if (winner_d == W_P1 && score1_q != WIN) score1_d = score1_q + 1'b1;
            if (winner_d == W_P2 && score2_q != WIN) score2_d = score2_q + 1'b1;
        end

        if (round_clear || restart) begin
            stored1_d      = '0;
            stored2_d      = '0;
            rolled1_d      = 1'b0;
            rolled2_d      = 1'b0;
            winner_d       = W_NONE;
            dreimann_d     = '0;
            result_valid_d = 1'b0;
        end
        if (restart) begin
            score1_d = '0;
            score2_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stored1_q      <= '0;
            stored2_q      <= '0;
            rolled1_q      <= 1'b0;
            rolled2_q      <= 1'b0;
            pending_q      <= 1'b0;
            judge_q        <= 1'b0;
            winner_q       <= W_NONE;
            dreimann_q     <= '0;
            result_valid_q <= 1'b0;
            score1_q       <= '0;
            score2_q       <= '0;
        end else begin
            stored1_q      <= stored1_d;
            stored2_q      <= stored2_d;
            rolled1_q      <= rolled1_d;
            rolled2_q      <= rolled2_d;
            pending_q      <= pending_d;
            judge_q        <= judge_d;
            winner_q       <= winner_d;
            dreimann_q     <= dreimann_d;
            result_valid_q <= result_valid_d;
            score1_q       <= score1_d;
            score2_q       <= score2_d;
        end
    end

    assign stored1_o      = stored1_q;
    assign stored2_o      = stored2_q;
    assign rolled1_o      = rolled1_q;
    assign rolled2_o      = rolled2_q;
    assign result_valid_o = result_valid_q;
    assign winner_o       = winner_q;
    assign dreimann_o     = dreimann_q;
    assign score1_o       = score1_q;
    assign score2_o       = score2_q;

endmodule

// File: tb/tb_dice_round_sequencer.sv
module tb_dice_round_sequencer;
  import dice_pkg::*;

  localparam int HOLD = 4;
  localparam int WIN  = 2;
  localparam int SW   = 3;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req1, req2;
  logic [2:0]    val;
  logic [2:0]    stored1, stored2;
  logic          rolled1, rolled2, turn, result_valid, game_over;
  logic [1:0]    winner, dreimann;
  logic [SW-1:0] score1, score2;
  state_e        dbg_state;

  dice_round_sequencer #(
    .HOLD_CYCLES(HOLD),
    .WIN_SCORE  (WIN),
    .SCORE_W    (SW)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .roll_req1_i   (req1),
    .roll_req2_i   (req2),
    .running_val_i (val),
    .stored1_o     (stored1),
    .stored2_o     (stored2),
    .rolled1_o     (rolled1),
    .rolled2_o     (rolled2),
    .turn_o        (turn),
    .result_valid_o(result_valid),
    .winner_o      (winner),
    .dreimann_o    (dreimann),
    .score1_o      (score1),
    .score2_o      (score2),
    .game_over_o   (game_over),
    .state_o       (dbg_state)
  );

  // reference model: game-level bookkeeping
  int         n_tests = 0;
  int         n_fail  = 0;
  int         m_s1 = 0;
  int         m_s2 = 0;
  bit         m_over = 1'b0;
  logic [1:0] exp_q[$];

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_stored1"}, 8'(stored1), 8'd0);
    check({tag, "_stored2"}, 8'(stored2), 8'd0);
    check({tag, "_rolled1"}, 8'(rolled1), 8'd0);
    check({tag, "_rolled2"}, 8'(rolled2), 8'd0);
    check({tag, "_turn"}, 8'(turn), 8'd0);
    check({tag, "_rvalid"}, 8'(result_valid), 8'd0);
    check({tag, "_winner"}, 8'(winner), 8'd0);
    check({tag, "_dreimann"}, 8'(dreimann), 8'd0);
    check({tag, "_gameover"}, 8'(game_over), 8'd0);
    check({tag, "_score1"}, 8'(score1), 8'(m_s1));
    check({tag, "_score2"}, 8'(score2), 8'(m_s2));
  endtask

  // driver: player p rolls d, optionally after n_ill cycles of illegal values
  task automatic roll_player(input int p, input logic [2:0] d, input int n_ill);
    for (int i = 0; i < n_ill; i++) begin
      if (p == 1) req1 = (i == 0); else req2 = (i == 0);
      val = ($urandom_range(0, 1) == 1) ? 3'd7 : 3'd0;
      tick();
      req1 = 1'b0;
      req2 = 1'b0;
      if (p == 1) check("pend_rolled1", 8'(rolled1), 8'd0);
      else        check("pend_rolled2", 8'(rolled2), 8'd0);
    end
    val = d;
    if (n_ill == 0) begin
      if (p == 1) req1 = 1'b1; else req2 = 1'b1;
    end
    tick();
    req1 = 1'b0;
    req2 = 1'b0;
    val  = 3'($urandom_range(0, 7));
    if (p == 1) begin
      check("p1_stored1", 8'(stored1), 8'(d));
      check("p1_rolled1", 8'(rolled1), 8'd1);
      check("p1_rolled2", 8'(rolled2), 8'd0);
      check("p1_turn", 8'(turn), 8'd1);
    end else begin
      check("p2_stored2", 8'(stored2), 8'(d));
      check("p2_rolled2", 8'(rolled2), 8'd1);
      check("p2_rvalid_early", 8'(result_valid), 8'd0);
    end
  endtask

  // P2 roll, verdict, hold and exit; P1 already holds d1
  task automatic p2_and_judge(input logic [2:0] d1, input logic [2:0] d2, input int n_ill2);
    logic [1:0] ew, ed;
    roll_player(2, d2, n_ill2);
    if (d1 > d2)      exp_q.push_back(2'b01);
    else if (d2 > d1) exp_q.push_back(2'b10);
    else              exp_q.push_back(2'b11);
    ed = {d2 == 3'd3, d1 == 3'd3};
    tick();
    ew = exp_q.pop_front();
    if (ew == 2'b01 && m_s1 < WIN) m_s1++;
    if (ew == 2'b10 && m_s2 < WIN) m_s2++;
    m_over = (m_s1 == WIN) || (m_s2 == WIN);
    check("res_winner", 8'(winner), 8'(ew));
    check("res_dreimann", 8'(dreimann), 8'(ed));
    check("res_rvalid", 8'(result_valid), 8'd1);
    check("res_score1", 8'(score1), 8'(m_s1));
    check("res_score2", 8'(score2), 8'(m_s2));
    // requests during the hold must be ignored
    for (int i = 1; i < HOLD; i++) begin
      req1 = 1'($urandom_range(0, 1));
      req2 = 1'($urandom_range(0, 1));
      val  = 3'($urandom_range(1, 6));
      tick();
      req1 = 1'b0;
      req2 = 1'b0;
    end
    check("hold_rvalid", 8'(result_valid), 8'd1);
    check("hold_stored1", 8'(stored1), 8'(d1));
    check("hold_winner", 8'(winner), 8'(ew));
    tick();
    if (m_over) begin
      check("go_flag", 8'(game_over), 8'd1);
      check("go_state", 8'(dbg_state), 8'(GAME_OVER));
      check("go_rvalid", 8'(result_valid), 8'd1);
      check("go_winner", 8'(winner), 8'(ew));
      check("go_stored1", 8'(stored1), 8'(d1));
      check("go_stored2", 8'(stored2), 8'(d2));
      check("go_score1", 8'(score1), 8'(m_s1));
      check("go_score2", 8'(score2), 8'(m_s2));
    end else begin
      check_idle("after_hold");
    end
  endtask

  task automatic play_round(input logic [2:0] d1, input logic [2:0] d2, input int n1, input int n2);
    roll_player(1, d1, n1);
    p2_and_judge(d1, d2, n2);
  endtask

  task automatic game_over_exit();
    for (int i = 0; i < 3; i++) begin
      req2 = 1'b1;
      val  = 3'($urandom_range(1, 6));
      tick();
      req2 = 1'b0;
      check("go_req2_ignored", 8'(game_over), 8'd1);
      check("go_frozen_s1", 8'(score1), 8'(m_s1));
    end
    req1 = 1'b1;
    tick();
    req1   = 1'b0;
    m_s1   = 0;
    m_s2   = 0;
    m_over = 1'b0;
    check_idle("restart");
  endtask

  initial begin
    logic [2:0] d1, d2;
    // reset with requests asserted
    rst  = 1'b1;
    req1 = 1'b1;
    req2 = 1'b1;
    val  = 3'd5;
    tick();
    tick();
    check_idle("reset");
    check("reset_state", 8'(dbg_state), 8'(WAIT_P1));
    rst  = 1'b0;
    req1 = 1'b0;
    req2 = 1'b0;
    tick();
    check_idle("post_reset");

    // basic round: P1 5 vs P2 2
    play_round(3'd5, 3'd2, 0, 0);

    // illegal values: 0, then 7, then 3
    req1 = 1'b1;
    val  = 3'd0;
    tick();
    req1 = 1'b0;
    check("ill0_rolled1", 8'(rolled1), 8'd0);
    check("ill0_turn", 8'(turn), 8'd0);
    val = 3'd7;
    tick();
    check("ill7_rolled1", 8'(rolled1), 8'd0);
    val = 3'd3;
    tick();
    check("ill_stored1", 8'(stored1), 8'd3);
    check("ill_turn", 8'(turn), 8'd1);
    p2_and_judge(3'd3, 3'd3, 0);

    // turn order: req2 in WAIT_P1, req1+req2 together, req1 in WAIT_P2
    req2 = 1'b1;
    val  = 3'd4;
    tick();
    req2 = 1'b0;
    check("ord_p2_early_rolled2", 8'(rolled2), 8'd0);
    check("ord_p2_early_rolled1", 8'(rolled1), 8'd0);
    check("ord_p2_early_turn", 8'(turn), 8'd0);
    req1 = 1'b1;
    req2 = 1'b1;
    val  = 3'd6;
    tick();
    req1 = 1'b0;
    req2 = 1'b0;
    check("ord_sim_stored1", 8'(stored1), 8'd6);
    check("ord_sim_rolled2", 8'(rolled2), 8'd0);
    check("ord_sim_turn", 8'(turn), 8'd1);
    req1 = 1'b1;
    val  = 3'd1;
    tick();
    req1 = 1'b0;
    check("ord_p1_late_stored1", 8'(stored1), 8'd6);
    check("ord_p1_late_rolled2", 8'(rolled2), 8'd0);
    p2_and_judge(3'd6, 3'd2, 0);   // second P1 win: game over
    check("game_end_model", 8'(m_over), 8'd1);
    if (m_over) game_over_exit();

    // randomized rounds
    for (int r = 0; r < 14; r++) begin
      d1 = 3'($urandom_range(1, 6));
      d2 = 3'($urandom_range(1, 6));
      play_round(d1, d2, $urandom_range(0, 2), $urandom_range(0, 2));
      if (m_over) game_over_exit();
    end

    // reset in the middle of a hold (hold count 2)
    roll_player(1, 3'd4, 0);
    roll_player(2, 3'd1, 0);
    tick();
    tick();
    tick();
    check("midhold_rvalid_before", 8'(result_valid), 8'd1);
    rst  = 1'b1;
    req1 = 1'b1;
    tick();
    rst  = 1'b0;
    req1 = 1'b0;
    m_s1 = 0;
    m_s2 = 0;
    m_over = 1'b0;
    check_idle("midhold_reset");
    check("midhold_state", 8'(dbg_state), 8'(WAIT_P1));
    play_round(3'd2, 3'd5, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
